// File: rtl/vpu_issue_ctrl.sv
// Per-request issue sequencer for the VPU: pops one decoded request, starts
// operand fetch on the selected SRAM read ports, issues to the fixed-latency
// execute pipe, waits for write-back, then clears the ports. Single request
// in flight; timeouts, abort and a completed-op counter are included.
module vpu_issue_ctrl #(
  parameter int SRC_PORT_CNT   = 3,
  parameter int OPCODE_WIDTH   = 5,
  parameter int EXEC_LATENCY   = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_empty_i,
  input  logic [OPCODE_WIDTH-1:0] req_opcode_i,
  input  logic [SRC_PORT_CNT-1:0] req_src_mask_i,
  output logic                    req_rden_o,
  output logic                    src_start_o,
  output logic [SRC_PORT_CNT-1:0] src_mask_o,
  input  logic [SRC_PORT_CNT-1:0] opget_done_i,
  output logic [SRC_PORT_CNT-1:0] operand_rden_o,
  output logic                    exec_valid_o,
  output logic [OPCODE_WIDTH-1:0] exec_opcode_o,
  output logic                    wb_wren_o,
  input  logic                    wb_done_i,
  output logic                    reset_cmd_o,
  input  logic                    abort_i,
  input  logic                    err_clr_i,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output logic [CNT_WIDTH-1:0]    done_cnt_o
);

  // Timer only has to reach TIMEOUT_CYCLES-1; a zero limit disables it.
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int LAT_W = $clog2(EXEC_LATENCY + 1);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  // Latency count value in the cycle just before write-back enable.
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(EXEC_LATENCY - 1);

  localparam logic [1:0] ERR_FETCH = 2'd1;
  localparam logic [1:0] ERR_WB    = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    WB    = 3'd4,
    CLEAR = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [SRC_PORT_CNT-1:0] done_sticky_q;
  logic [TMR_W-1:0]        tmr_q;
  logic [LAT_W-1:0]        lat_cnt_q;

  logic                    pop;
  logic                    fetch_complete;
  logic                    tmo_exp;
  logic                    tmo_fire;
  logic [1:0]              tmo_code;
  logic                    cnt_inc;
  logic                    wren_d;

  // Decoder-queue pop is combinational so the head entry is taken this cycle.
  assign pop        = (state_q == IDLE) && !req_empty_i;
  assign req_rden_o = pop && !rst;

  // A done pulse in the same cycle as the last missing port still completes.
  assign fetch_complete =
    ((done_sticky_q | (opget_done_i & src_mask_o)) == src_mask_o);
  assign tmo_exp = (TIMEOUT_CYCLES != 0) && (tmr_q == TMR_LAST);

  // Next-state logic; abort beats completion, completion beats timeout.
  always_comb begin
    state_d  = state_q;
    tmo_fire = 1'b0;
    tmo_code = 2'd0;
    cnt_inc  = 1'b0;
    wren_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!req_empty_i) begin
          state_d = (req_src_mask_i == '0) ? ISSUE : FETCH;
        end
      end
      FETCH: begin
        if (abort_i) begin
          state_d = CLEAR;
        end else if (fetch_complete) begin
          state_d = ISSUE;
        end else if (tmo_exp) begin
          state_d  = CLEAR;
          tmo_fire = 1'b1;
          tmo_code = ERR_FETCH;
        end
      end
      ISSUE: begin
        wren_d  = (EXEC_LATENCY == 1) && !abort_i;
        state_d = abort_i ? CLEAR : EXEC;
      end
      EXEC: begin
        if (abort_i) begin
          state_d = CLEAR;
        end else begin
          wren_d = (lat_cnt_q == LAT_LAST);
          if (wb_wren_o) begin
            state_d = WB;
          end
        end
      end
      WB: begin
        if (abort_i) begin
          state_d = CLEAR;
        end else if (wb_done_i) begin
          state_d = CLEAR;
          cnt_inc = 1'b1;
        end else if (tmo_exp) begin
          state_d  = CLEAR;
          tmo_fire = 1'b1;
          tmo_code = ERR_WB;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register and registered one-cycle strobes derived from transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_o         <= 1'b0;
      src_start_o    <= 1'b0;
      operand_rden_o <= '0;
      exec_valid_o   <= 1'b0;
      wb_wren_o      <= 1'b0;
      reset_cmd_o    <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_o         <= (state_d != IDLE);
      src_start_o    <= (state_q == IDLE) && (state_d == FETCH);
      operand_rden_o <= ((state_q == FETCH) && (state_d == ISSUE)) ? src_mask_o : '0;
      exec_valid_o   <= (state_d == ISSUE);
      wb_wren_o      <= wren_d;
      reset_cmd_o    <= (state_d == CLEAR);
    end
  end

  // Request fields latched at pop; the mask is dropped once the port clear ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_mask_o    <= '0;
      exec_opcode_o <= '0;
    end else if (pop) begin
      src_mask_o    <= req_src_mask_i;
      exec_opcode_o <= req_opcode_i;
    end else if (state_q == CLEAR) begin
      src_mask_o    <= '0;
    end
  end

  // Sticky per-port fetch-done tracking, masked to the ports in use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_sticky_q <= '0;
    end else if (state_q == FETCH) begin
      done_sticky_q <= done_sticky_q | (opget_done_i & src_mask_o);
    end else begin
      done_sticky_q <= '0;
    end
  end

  // Wait timer restarts on every state change, so it is zero on FETCH/WB entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (state_d != state_q) begin
      tmr_q <= '0;
    end else if ((state_q == FETCH) || (state_q == WB)) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  // Cycles elapsed since the issue cycle, used to place the write-back enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      lat_cnt_q <= LAT_W'(1);
    end else if (state_q == EXEC) begin
      lat_cnt_q <= lat_cnt_q + 1'b1;
    end
  end

  // Sticky error flag; a timeout in the same cycle outranks a clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
    end else if (tmo_fire) begin
      err_o <= 1'b1;
      if (err_code_o == 2'd0) begin
        err_code_o <= tmo_code;
      end
    end else if (err_clr_i) begin
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
    end
  end

  // Completed-request counter, wraps naturally at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cnt_o <= '0;
    end else if (cnt_inc) begin
      done_cnt_o <= done_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Scoreboard bench for vpu_issue_ctrl: stimulus pushes expected events
// (fetch start, issue, write-back enable, port clear) with their cycle offset
// from the request pop; a monitor pops and compares as the DUT emits them.
module tb_vpu_issue_ctrl;

  localparam int NP  = 3;
  localparam int OPW = 5;
  localparam int CW  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_empty_i = 1'b1;
  logic [OPW-1:0]  req_opcode_i = '0;
  logic [NP-1:0]   req_src_mask_i = '0;
  logic            req_rden_o;
  logic            src_start_o;
  logic [NP-1:0]   src_mask_o;
  logic [NP-1:0]   opget_done_i = '0;
  logic [NP-1:0]   operand_rden_o;
  logic            exec_valid_o;
  logic [OPW-1:0]  exec_opcode_o;
  logic            wb_wren_o;
  logic            wb_done_i = 1'b0;
  logic            reset_cmd_o;
  logic            abort_i = 1'b0;
  logic            err_clr_i = 1'b0;
  logic            busy_o;
  logic            err_o;
  logic [1:0]      err_code_o;
  logic [CW-1:0]   done_cnt_o;

  vpu_issue_ctrl #(
    .SRC_PORT_CNT(NP), .OPCODE_WIDTH(OPW), .EXEC_LATENCY(4),
    .TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_empty_i(req_empty_i), .req_opcode_i(req_opcode_i),
    .req_src_mask_i(req_src_mask_i), .req_rden_o(req_rden_o),
    .src_start_o(src_start_o), .src_mask_o(src_mask_o),
    .opget_done_i(opget_done_i), .operand_rden_o(operand_rden_o),
    .exec_valid_o(exec_valid_o), .exec_opcode_o(exec_opcode_o),
    .wb_wren_o(wb_wren_o), .wb_done_i(wb_done_i),
    .reset_cmd_o(reset_cmd_o), .abort_i(abort_i), .err_clr_i(err_clr_i),
    .busy_o(busy_o), .err_o(err_o), .err_code_o(err_code_o),
    .done_cnt_o(done_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [NP-1:0] mask; int off; } start_t;
  typedef struct { logic [OPW-1:0] op; logic [NP-1:0] rden; int off; } issue_t;
  typedef struct { logic err; logic [1:0] code; logic [CW-1:0] cnt; int off; } clear_t;

  start_t start_q[$];
  issue_t issue_q[$];
  int     wren_q[$];
  clear_t clear_q[$];
  logic [OPW+NP-1:0] req_fifo[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected pulse expected none (cycle %0d)", name, cyc);
  endtask

  // Decoder queue model: show-ahead head, popped after a sampled req_rden_o.
  initial begin
    logic pp;
    forever begin
      @(negedge clk);
      pp = req_rden_o;
      @(posedge clk);
      #2;
      if (pp && req_fifo.size() > 0) void'(req_fifo.pop_front());
      req_empty_i = (req_fifo.size() == 0);
      if (req_fifo.size() > 0) {req_opcode_i, req_src_mask_i} = req_fifo[0];
    end
  end

  // Monitor: compares every emitted event against the scoreboard queues.
  int     last_pop = 0;
  start_t s_e;
  issue_t i_e;
  int     w_e;
  clear_t c_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (req_rden_o) last_pop = cyc;
      if (src_start_o) begin
        if (start_q.size() == 0) unexpected("src_start");
        else begin
          s_e = start_q.pop_front();
          check("start_mask", 32'(src_mask_o), 32'(s_e.mask));
          check("start_cycle", cyc - last_pop, s_e.off);
        end
      end
      if (exec_valid_o) begin
        if (issue_q.size() == 0) unexpected("exec_valid");
        else begin
          i_e = issue_q.pop_front();
          check("issue_opcode", 32'(exec_opcode_o), 32'(i_e.op));
          check("issue_rden", 32'(operand_rden_o), 32'(i_e.rden));
          check("issue_cycle", cyc - last_pop, i_e.off);
        end
      end else if (operand_rden_o != '0) begin
        unexpected("operand_rden");
      end
      if (wb_wren_o) begin
        if (wren_q.size() == 0) unexpected("wb_wren");
        else begin
          w_e = wren_q.pop_front();
          check("wren_cycle", cyc - last_pop, w_e);
        end
      end
      if (reset_cmd_o) begin
        if (clear_q.size() == 0) unexpected("reset_cmd");
        else begin
          c_e = clear_q.pop_front();
          check("clear_err", 32'(err_o), 32'(c_e.err));
          check("clear_code", 32'(err_code_o), 32'(c_e.code));
          check("clear_cnt", 32'(done_cnt_o), 32'(c_e.cnt));
          check("clear_cycle", cyc - last_pop, c_e.off);
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pop(output int p);
    bit found = 0;
    p = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_rden_o) begin
        p = cyc;
        found = 1;
        break;
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL pop_timeout: got no req_rden_o expected a pop within 40 cycles");
    end
  endtask

  task automatic pulse_done(input int t, input logic [NP-1:0] v);
    goto(t);
    opget_done_i = v;
    goto(t + 1);
    opget_done_i = '0;
  endtask

  task automatic pulse_wb(input int t);
    goto(t);
    wb_done_i = 1'b1;
    goto(t + 1);
    wb_done_i = 1'b0;
  endtask

  task automatic clear_err(input int t);
    goto(t);
    err_clr_i = 1'b1;
    goto(t + 1);
    err_clr_i = 1'b0;
    check("err_after_clr", {30'd0, err_o, 1'b0} | 32'(err_code_o), 32'd0);
  endtask

  initial begin
    int p, q;
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    int p, q;
    // Reset with a request already waiting: no pop, every output zero.
    req_fifo.push_back({5'h11, 3'b111});
    repeat (3) @(posedge clk);
    #3;
    check("rst_req_empty", 32'(req_empty_i), 32'd0);
    check("rst_outputs", 32'({req_rden_o, src_start_o, src_mask_o, operand_rden_o,
          exec_valid_o, exec_opcode_o, wb_wren_o, reset_cmd_o, busy_o, err_o,
          err_code_o, done_cnt_o}), 32'd0);

    // Full mask, staggered dones.
    start_q.push_back('{3'b111, 1});
    issue_q.push_back('{5'h11, 3'b111, 6});
    wren_q.push_back(10);
    clear_q.push_back('{1'b0, 2'd0, 2'd1, 13});
    goto(cyc + 1);
    rst = 1'b0;
    wait_pop(p);
    pulse_done(p + 3, 3'b001);
    pulse_done(p + 4, 3'b100);
    pulse_done(p + 5, 3'b010);
    pulse_wb(p + 12);
    goto(p + 15);

    // Single port with spurious dones on unmasked ports.
    req_fifo.push_back({5'h0A, 3'b010});
    start_q.push_back('{3'b010, 1});
    issue_q.push_back('{5'h0A, 3'b010, 6});
    wren_q.push_back(10);
    clear_q.push_back('{1'b0, 2'd0, 2'd2, 12});
    wait_pop(p);
    pulse_done(p + 2, 3'b101);
    pulse_done(p + 3, 3'b101);
    pulse_done(p + 5, 3'b010);
    pulse_wb(p + 11);
    goto(p + 14);

    // Fetch timeout, then error clear.
    req_fifo.push_back({5'h03, 3'b001});
    start_q.push_back('{3'b001, 1});
    clear_q.push_back('{1'b1, 2'd1, 2'd2, 9});
    wait_pop(p);
    goto(p + 10);
    check("err_sticky_fetch", 32'(err_o), 32'd1);
    clear_err(p + 10);

    // Empty mask; write-back done on the expiry cycle wins.
    req_fifo.push_back({5'h07, 3'b000});
    issue_q.push_back('{5'h07, 3'b000, 1});
    wren_q.push_back(5);
    clear_q.push_back('{1'b0, 2'd0, 2'd3, 14});
    wait_pop(p);
    pulse_wb(p + 13);
    goto(p + 16);

    // Empty mask, no write-back done: write-back timeout.
    req_fifo.push_back({5'h09, 3'b000});
    issue_q.push_back('{5'h09, 3'b000, 1});
    wren_q.push_back(5);
    clear_q.push_back('{1'b1, 2'd2, 2'd3, 14});
    wait_pop(p);
    goto(p + 16);
    check("err_code_wb", 32'(err_code_o), 32'd2);
    clear_err(p + 16);

    // Abort in EXEC with a second request queued behind it.
    req_fifo.push_back({5'h15, 3'b100});
    req_fifo.push_back({5'h16, 3'b011});
    start_q.push_back('{3'b100, 1});
    issue_q.push_back('{5'h15, 3'b100, 3});
    clear_q.push_back('{1'b0, 2'd0, 2'd3, 7});
    start_q.push_back('{3'b011, 1});
    issue_q.push_back('{5'h16, 3'b011, 3});
    wren_q.push_back(7);
    clear_q.push_back('{1'b0, 2'd0, 2'd0, 9});
    wait_pop(p);
    pulse_done(p + 2, 3'b100);
    goto(p + 6);
    abort_i = 1'b1;
    goto(p + 7);
    abort_i = 1'b0;
    wait_pop(q);
    check("next_pop_after_abort", q - p, 8);
    pulse_done(q + 2, 3'b011);
    pulse_wb(q + 8);
    goto(q + 11);

    // Fifth completion wraps the 2-bit counter to 1; done in first fetch cycle.
    req_fifo.push_back({5'h1F, 3'b001});
    start_q.push_back('{3'b001, 1});
    issue_q.push_back('{5'h1F, 3'b001, 2});
    wren_q.push_back(6);
    clear_q.push_back('{1'b0, 2'd0, 2'd1, 8});
    wait_pop(p);
    pulse_done(p + 1, 3'b001);
    pulse_wb(p + 7);
    goto(p + 10);

    // Asynchronous reset while in FETCH.
    req_fifo.push_back({5'h02, 3'b001});
    start_q.push_back('{3'b001, 1});
    wait_pop(p);
    goto(p + 2);
    check("busy_before_rst", 32'({busy_o, done_cnt_o}), 32'({1'b1, 2'd1}));
    rst = 1'b1;
    #1;
    check("rst_async_outputs", 32'({req_rden_o, src_start_o, src_mask_o, operand_rden_o,
          exec_valid_o, exec_opcode_o, wb_wren_o, reset_cmd_o, busy_o, err_o,
          err_code_o, done_cnt_o}), 32'd0);
    goto(p + 4);
    rst = 1'b0;
    goto(p + 8);

    // Counter restarts from zero after reset.
    req_fifo.push_back({5'h04, 3'b000});
    issue_q.push_back('{5'h04, 3'b000, 1});
    wren_q.push_back(5);
    clear_q.push_back('{1'b0, 2'd0, 2'd1, 7});
    wait_pop(p);
    pulse_wb(p + 6);
    goto(p + 12);

    check("start_q_drained", start_q.size(), 0);
    check("issue_q_drained", issue_q.size(), 0);
    check("wren_q_drained", wren_q.size(), 0);
    check("clear_q_drained", clear_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
